onchip_memory_arbiter: RTL and testbench

//   Two-master Avalon-MM arbiter sharing one single-port 32-bit on-chip RAM.
//   The RAM has a registered address and an unregistered output, so read latency is 1.

---
 rtl/onchip_memory_arbiter_if.sv | 53 +++++
 rtl/onchip_memory_arbiter.sv | 78 +++++++
 tb/tb_onchip_memory_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/onchip_memory_arbiter_if.sv
// Avalon-MM signal bundle for the two-master on-chip RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface onchip_memory_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8
);
   logic [ADDR_W-1:0] m0_address;
   logic              m0_read;
   logic              m0_write;
   logic [BE_W-1:0]   m0_byteenable;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   logic [ADDR_W-1:0] m1_address;
   logic              m1_read;
   logic              m1_write;
   logic [BE_W-1:0]   m1_byteenable;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   modport slave (
      input  m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write,
      output mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport master (
      output m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write,
      input  mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port RAM with read latency 1.
// Define ONCHIP_ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module onchip_memory_arbiter #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8
) (
   input logic                  clk,
   input logic                  reset,
   onchip_memory_arbiter_if.slave bus
);
   logic              w_req0, w_req1;
   logic              w_gnt0, w_gnt1;
   logic              w_rd_issue;
   logic              w_rr_sel;
   logic [ADDR_W-1:0] w_addr;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] w_wdata;

   logic              r_rd_vld_p1;
   logic              r_rd_id_p1;

   assign w_req0 = bus.m0_read | bus.m0_write;
   assign w_req1 = bus.m1_read | bus.m1_write;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
   assign w_rr_sel = 1'b0;
`else
   logic r_rr_ptr;
   assign w_rr_sel = r_rr_ptr;

   // Pointer moves only when both masters contended, pointing away from the winner
   always_ff @(posedge clk) begin
      if (reset)
         r_rr_ptr <= 1'b0;
      else if (w_req0 && w_req1)
         r_rr_ptr <= w_gnt0;
   end
`endif

   // Grant is suppressed during reset so the RAM sees no command
   assign w_gnt0 = ~reset & w_req0 & (~w_req1 | ~w_rr_sel);
   assign w_gnt1 = ~reset & w_req1 & (~w_req0 |  w_rr_sel);

   assign w_addr  = w_gnt1 ? bus.m1_address    : bus.m0_address;
   assign w_be    = w_gnt1 ? bus.m1_byteenable : bus.m0_byteenable;
   assign w_wdata = w_gnt1 ? bus.m1_writedata  : bus.m0_writedata;

   assign bus.mem_address    = w_addr;
   assign bus.mem_byteenable = w_be;
   assign bus.mem_writedata  = w_wdata;
   assign bus.mem_chipselect = w_gnt0 | w_gnt1;
   assign bus.mem_write      = (w_gnt0 & bus.m0_write) | (w_gnt1 & bus.m1_write);
   assign bus.mem_clken      = 1'b1;

   // A read accompanied by a write is dropped: the write wins
   assign w_rd_issue = (w_gnt0 & bus.m0_read & ~bus.m0_write) |
                       (w_gnt1 & bus.m1_read & ~bus.m1_write);

   assign bus.m0_waitrequest = reset | (w_req0 & ~w_gnt0);
   assign bus.m1_waitrequest = reset | (w_req1 & ~w_gnt1);

   // p0 -> p1: RAM registers the address; tag the response with its issuer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_vld_p1 <= 1'b0;
         r_rd_id_p1  <= 1'b0;
      end else begin
         r_rd_vld_p1 <= w_rd_issue;
         r_rd_id_p1  <= w_gnt1;
      end
   end

   assign bus.m0_readdatavalid = ~reset & r_rd_vld_p1 & ~r_rd_id_p1;
   assign bus.m1_readdatavalid = ~reset & r_rd_vld_p1 &  r_rd_id_p1;
   assign bus.m0_readdata      = bus.mem_readdata;
   assign bus.m1_readdata      = bus.mem_readdata;
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter with a behavioural 1-cycle-latency RAM.
module tb_onchip_memory_arbiter;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   onchip_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

   onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: registered address, unregistered output
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] ram_addr_q;

   always @(posedge clk) begin
      if (bus.mem_clken) begin
         if (bus.mem_chipselect && bus.mem_write)
            for (int b = 0; b < BE_W; b++)
               if (bus.mem_byteenable[b])
                  ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
         ram_addr_q <= bus.mem_address;
      end
   end
   assign bus.mem_readdata = ram[ram_addr_q];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.m0_read = 1'b0; bus.m0_write = 1'b0;
      bus.m1_read = 1'b0; bus.m1_write = 1'b0;
   endtask

   initial begin
      int g;
      int pg;
      checks = 0;
      errors = 0;
      for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = '0;
      ram[15'h0010] = 32'hDEADBEEF;
      ram[15'h7FFF] = 32'h12340000;
      ram[15'h0020] = 32'h11111111;
      ram[15'h0030] = 32'h22222222;
      ram_addr_q = '0;

      reset = 1'b1;
      idle();
      bus.m0_address = 15'h0010; bus.m0_byteenable = 4'hF; bus.m0_writedata = '0;
      bus.m1_address = '0;       bus.m1_byteenable = 4'hF; bus.m1_writedata = '0;
      bus.m0_read = 1'b1;

      // Reset state with a pending request
      cyc(); cyc(); #2;
      chk("rst_m0_wait", bus.m0_waitrequest, 1);
      chk("rst_m1_wait", bus.m1_waitrequest, 1);
      chk("rst_cs", bus.mem_chipselect, 0);
      chk("rst_mwrite", bus.mem_write, 0);
      chk("rst_m0_rdv", bus.m0_readdatavalid, 0);
      chk("rst_m1_rdv", bus.m1_readdatavalid, 0);

      // Single read by m0
      cyc(); reset = 1'b0; #2;
      chk("t1_m0_wait", bus.m0_waitrequest, 0);
      chk("t1_cs", bus.mem_chipselect, 1);
      chk("t1_addr", bus.mem_address, 15'h0010);
      cyc(); idle(); #2;
      chk("t1_m0_rdv", bus.m0_readdatavalid, 1);
      chk("t1_m0_data", bus.m0_readdata, 32'hDEADBEEF);
      chk("t1_m1_rdv", bus.m1_readdatavalid, 0);

      // Read and write together: the write wins, no response follows
      cyc();
      bus.m0_read = 1'b1; bus.m0_write = 1'b1;
      bus.m0_address = 15'h0001; bus.m0_writedata = 32'h55; bus.m0_byteenable = 4'hF;
      #2;
      chk("t6_m0_wait", bus.m0_waitrequest, 0);
      chk("t6_mwrite", bus.mem_write, 1);
      chk("t6_wdata", bus.mem_writedata, 32'h55);
      chk("t6_addr", bus.mem_address, 15'h0001);
      cyc(); idle(); #2;
      chk("t6_m0_rdv", bus.m0_readdatavalid, 0);
      chk("t6_m1_rdv", bus.m1_readdatavalid, 0);

      // Partial write by m1 then read-back
      cyc();
      bus.m1_write = 1'b1; bus.m1_address = 15'h7FFF;
      bus.m1_writedata = 32'hA5A5A5A5; bus.m1_byteenable = 4'b0011;
      #2;
      chk("t2_m1_wait", bus.m1_waitrequest, 0);
      chk("t2_mwrite", bus.mem_write, 1);
      chk("t2_be", bus.mem_byteenable, 4'b0011);
      chk("t2_wdata", bus.mem_writedata, 32'hA5A5A5A5);
      cyc(); bus.m1_write = 1'b0; bus.m1_read = 1'b1; bus.m1_byteenable = 4'hF; #2;
      chk("t2_rd_wait", bus.m1_waitrequest, 0);
      chk("t2_rd_mwrite", bus.mem_write, 0);
      cyc(); idle(); #2;
      chk("t2_m1_rdv", bus.m1_readdatavalid, 1);
      chk("t2_m0_rdv", bus.m0_readdatavalid, 0);
      chk("t2_data", bus.m1_readdata, 32'h1234A5A5);

      // Both masters read continuously for 4 cycles after reset
      cyc(); reset = 1'b1;
      cyc(); reset = 1'b0;
      bus.m0_read = 1'b1; bus.m0_address = 15'h0020;
      bus.m1_read = 1'b1; bus.m1_address = 15'h0030;
      pg = 0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc();
         #2;
         g = FIXED ? 0 : (i % 2);
         chk($sformatf("t3_m0_wait_%0d", i), bus.m0_waitrequest, (g != 0));
         chk($sformatf("t3_m1_wait_%0d", i), bus.m1_waitrequest, (g != 1));
         chk($sformatf("t3_addr_%0d", i), bus.mem_address, (g == 1) ? 15'h0030 : 15'h0020);
         if (i > 0) begin
            chk($sformatf("t3_m0_rdv_%0d", i), bus.m0_readdatavalid, (pg == 0));
            chk($sformatf("t3_m1_rdv_%0d", i), bus.m1_readdatavalid, (pg == 1));
            chk($sformatf("t3_data_%0d", i), bus.m0_readdata,
                (pg == 1) ? 32'h22222222 : 32'h11111111);
         end
         pg = g;
      end
      cyc(); bus.m0_read = 1'b0; #2;
      chk("t3_m1_wait_drop", bus.m1_waitrequest, 0);
      chk("t3_m0_rdv_drop", bus.m0_readdatavalid, (pg == 0));
      chk("t3_m1_rdv_drop", bus.m1_readdatavalid, (pg == 1));
      cyc(); idle(); #2;
      chk("t3_m1_rdv_last", bus.m1_readdatavalid, 1);
      chk("t3_m0_rdv_last", bus.m0_readdatavalid, 0);
      chk("t3_data_last", bus.m1_readdata, 32'h22222222);

      // Reset the cycle after an m1 read grant
      cyc(); reset = 1'b1;
      cyc(); reset = 1'b0;
      bus.m0_read = 1'b1; bus.m1_read = 1'b1;
      #2;
      chk("t5_first_m0_wait", bus.m0_waitrequest, 0);
      cyc(); bus.m0_read = 1'b0; #2;
      chk("t5_m1_wait", bus.m1_waitrequest, 0);
      cyc(); bus.m1_read = 1'b0; reset = 1'b1; #2;
      chk("t5_m1_rdv_rst", bus.m1_readdatavalid, 0);
      chk("t5_m0_wait_rst", bus.m0_waitrequest, 1);
      cyc(); #2;
      chk("t5_m1_rdv_rst2", bus.m1_readdatavalid, 0);
      cyc(); reset = 1'b0; bus.m0_read = 1'b1; bus.m1_read = 1'b1; #2;
      chk("t5_m1_rdv_post", bus.m1_readdatavalid, 0);
      chk("t5_post_m0_wait", bus.m0_waitrequest, 0);
      chk("t5_post_m1_wait", bus.m1_waitrequest, 1);
      cyc(); idle(); #2;
      chk("t5_post_m0_rdv", bus.m0_readdatavalid, 1);
      chk("t5_post_data", bus.m0_readdata, 32'h11111111);

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
